fetch_sequencer: RTL and testbench

//  Program counter and fetch controller for the 3BC processor. Drives InstAddress into the
//  9-bit-wide, 1024-deep instruction ROM and sequences execution: entry-point selection,

---
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: selects an entry point, then steps the PC through
// the instruction ROM with stall, relative/absolute branch, halt and overrun detection.
module fetch_sequencer #(
  parameter int                ADDR_W      = 10,
  parameter int                CNT_W       = 16,
  parameter logic [ADDR_W-1:0] PROG_BASE_0 = 10'd0,
  parameter logic [ADDR_W-1:0] PROG_BASE_1 = 10'd256,
  parameter logic [ADDR_W-1:0] PROG_BASE_2 = 10'd512,
  parameter logic [ADDR_W-1:0] PROG_BASE_3 = 10'd768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        prog_sel,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_abs,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              halt,
  output logic [ADDR_W-1:0] inst_address,
  output logic              fetch_valid,
  output logic              ack,
  output logic              fault,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic              ack_r;
  logic              fault_r;
  logic              overrun_s;
  logic [CNT_W-1:0]  cycle_count_r;
  logic              fetch_valid_s;

  function automatic logic [ADDR_W-1:0] entry_base(input logic [1:0] sel);
    case (sel)
      2'd0:    entry_base = PROG_BASE_0;
      2'd1:    entry_base = PROG_BASE_1;
      2'd2:    entry_base = PROG_BASE_2;
      2'd3:    entry_base = PROG_BASE_3;
      default: entry_base = PROG_BASE_0;
    endcase
  endfunction

  // An ordinary increment from the top of the ROM ends the run instead of wrapping.
  assign overrun_s = ~stall & ~halt & ~branch_en & (pc_r == PC_MAX);

  // State register; ack is registered from the next state so it tracks DONE exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ack_r   <= (state_next_s == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (stall)          state_next_s = RUN;
        else if (halt)      state_next_s = DONE;
        else if (overrun_s) state_next_s = DONE;
        else                state_next_s = RUN;
      end
      DONE: begin
        if (!start) state_next_s = IDLE;
        else        state_next_s = DONE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    fetch_valid_s = 1'b0;
    if (state_r == RUN) fetch_valid_s = ~stall;
    else                fetch_valid_s = 1'b0;
  end

  // PC update priority while running: stall, halt, branch, increment.
  always_comb begin
    pc_next_s = pc_r;
    if (stall || halt || overrun_s) pc_next_s = pc_r;
    else if (branch_en) begin
      if (branch_abs) pc_next_s = branch_target;
      else            pc_next_s = pc_r + branch_target;
    end else          pc_next_s = pc_r + PC_ONE;
  end

  // PC, fault flag and saturating cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r          <= {ADDR_W{1'b0}};
      fault_r       <= 1'b0;
      cycle_count_r <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            pc_r          <= entry_base(prog_sel);
            fault_r       <= 1'b0;
            cycle_count_r <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          pc_r <= pc_next_s;
          if (overrun_s) fault_r <= 1'b1;
          if (cycle_count_r != CNT_MAX) cycle_count_r <= cycle_count_r + CNT_ONE;
        end
        DONE: begin
          pc_r <= pc_r;
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

  assign inst_address = pc_r;
  assign fetch_valid  = fetch_valid_s;
  assign ack          = ack_r;
  assign fault        = fault_r;
  assign cycle_count  = cycle_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized stimulus,
// all compared against a behavioural model of the run/halt/branch rules.
module tb_fetch_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       stall;
  logic       branch_en;
  logic       branch_abs;
  logic [9:0] branch_target;
  logic       halt;
  logic [9:0] inst_address;
  logic       fetch_valid;
  logic       ack;
  logic       fault;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: 0 = idle, 1 = running, 2 = finished
  int m_phase = 0;
  int m_pc    = 0;
  int m_cnt   = 0;
  int m_fault = 0;

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_sel(prog_sel), .stall(stall),
    .branch_en(branch_en), .branch_abs(branch_abs), .branch_target(branch_target),
    .halt(halt), .inst_address(inst_address), .fetch_valid(fetch_valid), .ack(ack),
    .fault(fault), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_cnt = 0; m_fault = 0;
  endtask

  task automatic model_edge();
    int off;
    if (m_phase == 0) begin
      if (start) begin
        m_phase = 1; m_pc = 256 * int'(prog_sel); m_cnt = 0; m_fault = 0;
      end
    end else if (m_phase == 1) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      if (stall) begin
      end else if (halt) begin
        m_phase = 2;
      end else if (branch_en) begin
        if (branch_abs) m_pc = int'(branch_target);
        else begin
          off  = branch_target[9] ? int'(branch_target) - 1024 : int'(branch_target);
          m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
        end
      end else if (m_pc == 1023) begin
        m_fault = 1; m_phase = 2;
      end else begin
        m_pc = m_pc + 1;
      end
    end else begin
      if (!start) m_phase = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    int'(inst_address), m_pc);
    check({tag, ".ack"},   int'(ack),          (m_phase == 2) ? 1 : 0);
    check({tag, ".fault"}, int'(fault),        m_fault);
    check({tag, ".cnt"},   int'(cycle_count),  m_cnt);
    check({tag, ".fv"},    int'(fetch_valid),  (m_phase == 1 && !stall) ? 1 : 0);
  endtask

  // One clock edge: update the model with the inputs seen at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic drive(input logic st, input logic [1:0] sel, input logic stl,
                       input logic ben, input logic babs, input logic [9:0] tgt,
                       input logic hlt);
    start = st; prog_sel = sel; stall = stl; branch_en = ben;
    branch_abs = babs; branch_target = tgt; halt = hlt;
  endtask

  initial begin
    int cnt_before;
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    model_reset();
    #2;
    check("reset.pc", int'(inst_address), 0);
    check("reset.ack", int'(ack), 0);
    check("reset.fv", int'(fetch_valid), 0);
    check("reset.cnt", int'(cycle_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Entry point 1, three increments, then halt
    drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    step("entry");
    check("entry.addr", int'(inst_address), 256);
    for (int i = 0; i < 3; i++) step("inc");
    halt = 1'b1;
    step("halt");
    check("halt.ack", int'(ack), 1);
    check("halt.cnt", int'(cycle_count), 4);
    check("halt.pc", int'(inst_address), 259);
    halt = 1'b0;

    // Start held high in DONE keeps Ack; dropping it returns to IDLE
    for (int i = 0; i < 5; i++) step("hold_ack");
    check("hold_ack.ack", int'(ack), 1);
    start = 1'b0;
    step("drop");
    check("drop.ack", int'(ack), 0);
    drive(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    step("restart");
    check("restart.cnt", int'(cycle_count), 0);
    check("restart.pc", int'(inst_address), 0);

    // Branches
    drive(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 10'd5, 1'b0);
    step("abs5");
    branch_target = 10'd700;
    step("abs700");
    check("abs700.pc", int'(inst_address), 700);
    branch_target = 10'd2;
    step("abs2");
    branch_abs = 1'b0; branch_target = 10'h3FC;
    step("rel_wrap");
    check("rel_wrap.pc", int'(inst_address), 1022);
    check("rel_wrap.fault", int'(fault), 0);
    branch_abs = 1'b1; branch_target = 10'd300;
    step("abs300");
    branch_abs = 1'b0; branch_target = 10'h3FC;
    step("rel_m4");
    check("rel_m4.pc", int'(inst_address), 296);

    // Stall overrides halt and branch
    cnt_before = int'(cycle_count);
    drive(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 10'd9, 1'b1);
    step("stall1");
    step("stall2");
    check("stall.pc", int'(inst_address), 296);
    check("stall.fv", int'(fetch_valid), 0);
    check("stall.cnt", int'(cycle_count), cnt_before + 2);
    check("stall.ack", int'(ack), 0);
    stall = 1'b0;
    step("halt_after_stall");
    check("halt_after_stall.ack", int'(ack), 1);
    check("halt_after_stall.pc", int'(inst_address), 296);
    drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    step("idle2");

    // Overrun from entry 3
    drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    step("ovr_entry");
    check("ovr_entry.pc", int'(inst_address), 768);
    for (int i = 0; i < 255; i++) step("ovr_run");
    check("ovr_top.pc", int'(inst_address), 1023);
    check("ovr_top.fault", int'(fault), 0);
    step("ovr");
    check("ovr.fault", int'(fault), 1);
    check("ovr.ack", int'(ack), 1);
    check("ovr.pc", int'(inst_address), 1023);
    start = 1'b0;
    step("ovr_drop");

    // Asynchronous reset in the middle of a run
    drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 10'd0, 1'b0);
    step("mid_entry");
    step("mid_run");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async.pc", int'(inst_address), 0);
    check("async.ack", int'(ack), 0);
    check("async.fv", int'(fetch_valid), 0);
    check("async.cnt", int'(cycle_count), 0);
    #2;
    start = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      start         = ($urandom_range(0, 7) != 0);
      prog_sel      = 2'($urandom_range(0, 3));
      stall         = ($urandom_range(0, 3) == 0);
      branch_en     = ($urandom_range(0, 5) == 0);
      branch_abs    = ($urandom_range(0, 1) == 1);
      branch_target = 10'($urandom_range(0, 1023));
      halt          = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
